// File: rtl/sim_periph_axi_slave_if.sv
// rtl/sim_periph_axi_slave_if.sv - AXI4 slave port bundle and the per-beat simulation call port.
// The call port carries one read or write access per beat to the simulated peripheral model.

interface sim_periph_axi_if #(
  parameter int ADDR_W = 64,
  parameter int ID_W   = 8,
  parameter int DATA_W = 64
);
  logic              awvalid, awready, awlock;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize, awprot;
  logic [1:0]        awburst;
  logic [3:0]        awcache, awqos, awregion;
  logic [ID_W-1:0]   awid;

  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  logic              arvalid, arready, arlock;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize, arprot;
  logic [1:0]        arburst;
  logic [3:0]        arcache, arqos, arregion;
  logic [ID_W-1:0]   arid;

  logic              rvalid, rready, rlast;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awid,
    input  awready,
    output wvalid, wlast, wdata, wstrb,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arid,
    input  arready,
    input  rvalid, rid, rresp, rdata, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awid,
    output awready,
    input  wvalid, wlast, wdata, wstrb,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arid,
    output arready,
    output rvalid, rid, rresp, rdata, rlast,
    input  rready
  );
endinterface

interface sim_periph_call_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                rd_en, wr_en;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic [DATA_W-1:0]   rd_data, wr_data;
  logic [DATA_W/8-1:0] wr_mask;

  modport host  (output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask, input  rd_data);
  modport model (input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask, output rd_data);
endinterface

// File: rtl/sim_periph_axi_slave.sv
// rtl/sim_periph_axi_slave.sv - single-outstanding AXI4 slave forwarding each beat to a sim peripheral.
// Read data is sampled from the call port in the cycle the beat is fetched.

module sim_periph_axi_slave #(
  parameter int                     AXI_ADDR_W = 64,
  parameter int                     AXI_ID_W   = 8,
  parameter int                     AXI_DATA_W = 64,
  parameter logic [AXI_ADDR_W-1:0]  BASE_ADDR  = 'h1000_0000,
  parameter logic [AXI_ADDR_W-1:0]  WIN_BYTES  = 'h1000_0000,
  parameter int                     RD_LAT     = 1
) (
  input  logic             aclk,
  input  logic             arst_n,
  sim_periph_axi_if.slave  mst,
  sim_periph_call_if.host  dpi,
  output logic             proto_err_o
);
  localparam int                    STRB_W    = AXI_DATA_W / 8;
  localparam int                    MAX_SIZE  = $clog2(STRB_W);
  localparam logic [AXI_ADDR_W-1:0] LANE_MASK = AXI_ADDR_W'(STRB_W - 1);
  localparam logic [AXI_ADDR_W-1:0] WIN_MASK  = WIN_BYTES - 1'b1;
  localparam bit                    LAT_ONE   = (RD_LAT <= 1);
  localparam logic [7:0]            LAT_INIT  = (RD_LAT > 1) ? 8'(RD_LAT - 2) : 8'd0;

  typedef enum logic [2:0] {S_IDLE, S_RLAT, S_RDATA, S_WDATA, S_WRESP} state_t;

  state_t                  state_q;
  logic                    prio_wr_q, rvalid_q, rlast_q, bvalid_q, proto_err_q;
  logic [AXI_ID_W-1:0]     id_q;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [7:0]              len_q, cnt_q, lat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q, resp_q;
  logic [AXI_DATA_W-1:0]   rdata_q;

  function automatic logic [1:0] decode_resp(input logic [AXI_ADDR_W-1:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
    if ((addr & ~WIN_MASK) != BASE_ADDR) return 2'd3;
    if (burst == 2'd3 || int'(size) > MAX_SIZE) return 2'd2;
    if (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) return 2'd2;
    return 2'd0;
  endfunction

  // WRAP keeps the bits above the (len+1)*2^size block and wraps the increment inside it.
  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0] addr, input logic [7:0] len,
                                                      input logic [2:0] size, input logic [1:0] burst);
    logic [AXI_ADDR_W-1:0] step, mask;
    step = AXI_ADDR_W'(1) << size;
    mask = ((AXI_ADDR_W'(len) + 1'b1) << size) - 1'b1;
    case (burst)
      2'd1:    return addr + step;
      2'd2:    return (addr & ~mask) | ((addr + step) & mask);
      default: return addr;
    endcase
  endfunction

  logic                  ar_hs, aw_hs, r_hs, w_hs, in_idle;
  logic [1:0]            ar_resp, aw_resp;
  logic [AXI_ADDR_W-1:0] nxt_addr;
  logic                  unused_sideband;

  assign in_idle     = arst_n && (state_q == S_IDLE);
  assign mst.arready = in_idle && mst.arvalid && (!mst.awvalid || !prio_wr_q);
  assign mst.awready = in_idle && mst.awvalid && (!mst.arvalid || prio_wr_q);
  assign mst.wready  = (state_q == S_WDATA);
  assign ar_hs       = mst.arvalid && mst.arready;
  assign aw_hs       = mst.awvalid && mst.awready;
  assign r_hs        = rvalid_q && mst.rready;
  assign w_hs        = mst.wvalid && mst.wready;
  assign ar_resp     = decode_resp(mst.araddr, mst.arlen, mst.arsize, mst.arburst);
  assign aw_resp     = decode_resp(mst.awaddr, mst.awlen, mst.awsize, mst.awburst);
  assign nxt_addr    = next_addr(addr_q, len_q, size_q, burst_q);

  assign dpi.rd_en   = (ar_hs && ar_resp == 2'd0) ||
                       (state_q == S_RDATA && r_hs && !rlast_q && resp_q == 2'd0);
  assign dpi.rd_addr = (in_idle ? mst.araddr : nxt_addr) & ~LANE_MASK;
  assign dpi.wr_en   = w_hs && resp_q == 2'd0;
  assign dpi.wr_addr = addr_q & ~LANE_MASK;
  assign dpi.wr_data = mst.wdata;
  assign dpi.wr_mask = mst.wstrb;

  assign mst.rvalid = rvalid_q;
  assign mst.rlast  = rlast_q;
  assign mst.rdata  = rdata_q;
  assign mst.rid    = id_q;
  assign mst.rresp  = resp_q;
  assign mst.bvalid = bvalid_q;
  assign mst.bid    = id_q;
  assign mst.bresp  = resp_q;
  assign proto_err_o = proto_err_q;

  assign unused_sideband = ^{mst.awlock, mst.awcache, mst.awprot, mst.awqos, mst.awregion,
                             mst.arlock, mst.arcache, mst.arprot, mst.arqos, mst.arregion};

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;  prio_wr_q <= 1'b0;  id_q <= '0;     addr_q <= '0;
      len_q <= '0;        size_q <= '0;       burst_q <= '0;  resp_q <= '0;
      cnt_q <= '0;        lat_q <= '0;        rdata_q <= '0;  rvalid_q <= 1'b0;
      rlast_q <= 1'b0;    bvalid_q <= 1'b0;   proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ar_hs) begin
            id_q <= mst.arid;  addr_q <= mst.araddr;  len_q <= mst.arlen;  size_q <= mst.arsize;
            burst_q <= mst.arburst;  resp_q <= ar_resp;  cnt_q <= mst.arlen;
            rlast_q   <= (mst.arlen == 8'd0);
            rdata_q   <= dpi.rd_en ? dpi.rd_data : '0;
            prio_wr_q <= 1'b1;
            state_q   <= LAT_ONE ? S_RDATA : S_RLAT;
            rvalid_q  <= LAT_ONE;
            lat_q     <= LAT_INIT;
          end else if (aw_hs) begin
            id_q <= mst.awid;  addr_q <= mst.awaddr;  len_q <= mst.awlen;  size_q <= mst.awsize;
            burst_q <= mst.awburst;  resp_q <= aw_resp;  cnt_q <= mst.awlen;
            prio_wr_q <= 1'b0;
            state_q   <= S_WDATA;
          end
        end
        S_RLAT: begin
          if (lat_q == 8'd0) begin
            state_q  <= S_RDATA;
            rvalid_q <= 1'b1;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        S_RDATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              state_q  <= S_IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              addr_q   <= nxt_addr;
              cnt_q    <= cnt_q - 1'b1;
              rlast_q  <= (cnt_q == 8'd1);
              rdata_q  <= dpi.rd_en ? dpi.rd_data : '0;
              state_q  <= LAT_ONE ? S_RDATA : S_RLAT;
              rvalid_q <= LAT_ONE;
              lat_q    <= LAT_INIT;
            end
          end
        end
        S_WDATA: begin
          if (w_hs) begin
            proto_err_q <= (mst.wlast != (cnt_q == 8'd0));
            if (cnt_q == 8'd0) begin
              state_q  <= S_WRESP;
              bvalid_q <= 1'b1;
            end else begin
              addr_q <= nxt_addr;
              cnt_q  <= cnt_q - 1'b1;
            end
          end
        end
        S_WRESP: begin
          if (mst.bready) begin
            bvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
